// File: rtl/semaforo_monitor.sv
// ============================================================================
// semaforo_monitor
//
// Passive checker for the six lamp lines of a two-way intersection
// controller. Each posedge it samples the lamps, decodes them into a phase
// code and checks the pattern, the phase transition and the dwell time
// against the day/night protocol. Errors are reported as one-cycle pulses,
// a sticky flag and a saturating event counter. All outputs are registered
// from the sample taken at the same edge.
//
// Optional feature (macro SEMAFORO_MON_STATS_EN):
//   adds output cycles_done, a 16-bit wrapping count of RY->GR transitions
//   seen while tracking (one completed day cycle each).
//
// Ports:
//   clock                      in   system clock, sampling on posedge
//   reset                      in   asynchronous active-high reset
//   redA, yellowA, greenA      in   lamp lines, road A
//   redB, yellowB, greenB      in   lamp lines, road B
//   phase[2:0]                 out  0 GR,1 YR,2 RG,3 RY,4 OFF,5 YY,7 INVALID
//   night                      out  decoded phase is OFF or YY
//   locked                     out  monitor is tracking a valid sequence
//   err_pattern                out  pulse: illegal lamp code
//   err_trans                  out  pulse: illegal phase transition
//   err_dwell                  out  pulse: dwell-time violation
//   err_sticky                 out  OR of all past error pulses
//   err_count[7:0]             out  erroring samples, saturating at 255
//   cycles_done[15:0]          out  (SEMAFORO_MON_STATS_EN only)
// ============================================================================
module semaforo_monitor #(
    parameter int GREEN_MIN     = 3,
    parameter int GREEN_MAX     = 4,
    parameter int YELLOW_CYCLES = 1,
    parameter int BLINK_CYCLES  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redA,
    input  logic        yellowA,
    input  logic        greenA,
    input  logic        redB,
    input  logic        yellowB,
    input  logic        greenB,
    output logic [2:0]  phase,
    output logic        night,
    output logic        locked,
    output logic        err_pattern,
    output logic        err_trans,
    output logic        err_dwell,
    output logic        err_sticky,
    output logic [7:0]  err_count
`ifdef SEMAFORO_MON_STATS_EN
    ,
    output logic [15:0] cycles_done
`endif
);

    localparam logic [2:0] PH_GR  = 3'd0;
    localparam logic [2:0] PH_YR  = 3'd1;
    localparam logic [2:0] PH_RG  = 3'd2;
    localparam logic [2:0] PH_RY  = 3'd3;
    localparam logic [2:0] PH_OFF = 3'd4;
    localparam logic [2:0] PH_YY  = 3'd5;
    localparam logic [2:0] PH_INV = 3'd7;

    localparam logic [3:0] DWELL_SAT = 4'd15;

    typedef enum logic {
        ST_SYNC  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Lamp order {redA, yellowA, greenA, redB, yellowB, greenB}.
    function automatic logic [2:0] f_decode(input logic [5:0] lamps);
        logic [2:0] ph;
        case (lamps)
            6'b001100: ph = PH_GR;
            6'b010100: ph = PH_YR;
            6'b100001: ph = PH_RG;
            6'b100010: ph = PH_RY;
            6'b000000: ph = PH_OFF;
            6'b010010: ph = PH_YY;
            default:   ph = PH_INV;
        endcase
        return ph;
    endfunction

    function automatic logic f_legal(input logic [2:0] from_ph, input logic [2:0] to_ph);
        logic ok;
        case ({from_ph, to_ph})
            {PH_GR,  PH_YR},
            {PH_YR,  PH_RG},
            {PH_RG,  PH_RY},
            {PH_RY,  PH_GR},
            {PH_GR,  PH_OFF},
            {PH_YR,  PH_OFF},
            {PH_RG,  PH_OFF},
            {PH_RY,  PH_OFF},
            {PH_OFF, PH_YY},
            {PH_YY,  PH_OFF},
            {PH_OFF, PH_GR},
            {PH_YY,  PH_GR}:  ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] f_limit(input logic [2:0] ph);
        logic [3:0] lim;
        case (ph)
            PH_GR, PH_RG: lim = 4'(GREEN_MAX);
            PH_YR, PH_RY: lim = 4'(YELLOW_CYCLES);
            default:      lim = 4'(BLINK_CYCLES);
        endcase
        return lim;
    endfunction

    logic [5:0] w_lamps;
    logic [2:0] w_code;
    logic       w_valid;
    logic [3:0] w_dwell_inc;
    logic [3:0] w_limit;

    state_t     r_state;
    logic [2:0] r_phase;
    logic [3:0] r_dwell;
    logic       r_night;
    logic       r_locked;
    logic       r_err_pat;
    logic       r_err_trans;
    logic       r_err_dwell;
    logic       r_sticky;
    logic [7:0] r_count;

    state_t     w_state_nxt;
    logic [2:0] w_phase_nxt;
    logic [3:0] w_dwell_nxt;
    logic       w_locked_nxt;
    logic       w_err_pat;
    logic       w_err_trans;
    logic       w_err_dwell;
    logic       w_any_err;
    logic       w_night_nxt;

    assign w_lamps     = {redA, yellowA, greenA, redB, yellowB, greenB};
    assign w_code      = f_decode(w_lamps);
    assign w_valid     = (w_code != PH_INV);
    assign w_dwell_inc = (r_dwell == DWELL_SAT) ? DWELL_SAT : r_dwell + 4'd1;
    assign w_limit     = f_limit(r_phase);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_dwell_nxt  = r_dwell;
        w_locked_nxt = r_locked;
        w_err_pat    = 1'b0;
        w_err_trans  = 1'b0;
        w_err_dwell  = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (w_valid) begin
                    // First valid sample only establishes the reference phase.
                    w_phase_nxt  = w_code;
                    w_dwell_nxt  = 4'd1;
                    w_locked_nxt = 1'b1;
                    w_state_nxt  = ST_TRACK;
                end else begin
                    w_err_pat   = 1'b1;
                    w_phase_nxt = PH_INV;
                end
            end
            ST_TRACK: begin
                if (!w_valid) begin
                    // Lost the sequence: no transition check against garbage.
                    w_err_pat    = 1'b1;
                    w_phase_nxt  = PH_INV;
                    w_dwell_nxt  = 4'd0;
                    w_locked_nxt = 1'b0;
                    w_state_nxt  = ST_SYNC;
                end else if (w_code == r_phase) begin
                    w_dwell_nxt = w_dwell_inc;
                    // Fires only on the sample where the limit is first crossed.
                    if ((r_dwell <= w_limit) && (w_dwell_inc > w_limit)) begin
                        w_err_dwell = 1'b1;
                    end
                end else begin
                    w_err_trans = !f_legal(r_phase, w_code);
                    // Green left early for its yellow; a switch to OFF is a mode
                    // change and never counts as a short green.
                    if (((r_phase == PH_GR && w_code == PH_YR) ||
                         (r_phase == PH_RG && w_code == PH_RY)) &&
                        (r_dwell < 4'(GREEN_MIN))) begin
                        w_err_dwell = 1'b1;
                    end
                    w_phase_nxt = w_code;
                    w_dwell_nxt = 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    assign w_any_err   = w_err_pat | w_err_trans | w_err_dwell;
    assign w_night_nxt = (w_phase_nxt == PH_OFF) || (w_phase_nxt == PH_YY);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_phase     <= PH_INV;
            r_dwell     <= 4'd0;
            r_night     <= 1'b0;
            r_locked    <= 1'b0;
            r_err_pat   <= 1'b0;
            r_err_trans <= 1'b0;
            r_err_dwell <= 1'b0;
            r_sticky    <= 1'b0;
            r_count     <= 8'd0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_dwell     <= w_dwell_nxt;
            r_night     <= w_night_nxt;
            r_locked    <= w_locked_nxt;
            r_err_pat   <= w_err_pat;
            r_err_trans <= w_err_trans;
            r_err_dwell <= w_err_dwell;
            r_sticky    <= r_sticky | w_any_err;
            // One count per erroring sample, regardless of how many flags fire.
            if (w_any_err && (r_count != 8'hFF)) begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign phase       = r_phase;
    assign night       = r_night;
    assign locked      = r_locked;
    assign err_pattern = r_err_pat;
    assign err_trans   = r_err_trans;
    assign err_dwell   = r_err_dwell;
    assign err_sticky  = r_sticky;
    assign err_count   = r_count;

`ifdef SEMAFORO_MON_STATS_EN
    logic        w_cycle_inc;
    logic [15:0] r_cycles;

    assign w_cycle_inc = (r_state == ST_TRACK) && (r_phase == PH_RY) && (w_code == PH_GR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycles <= 16'd0;
        end else if (w_cycle_inc) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign cycles_done = r_cycles;
`endif

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
- Passive checker at the receiving end of the traffic-light lamp interface. It samples the six lamp lines driven by the two-way intersection controller, decodes them into a phase code, and checks each pattern, phase transition and dwell time against the day/night protocol.
- It reports errors as single-cycle pulses, a sticky flag and a saturating counter.
- It sits beside the controller, for board-level self-check and simulation scoreboarding.

Parameters:
- GREEN_MIN, 3, minimum cycles a green phase (GR or RG) must last before going to its yellow phase.
- GREEN_MAX, 4, maximum cycles a green phase may last.
- YELLOW_CYCLES, 1, exact cycles of a yellow phase (YR or RY).
- BLINK_CYCLES, 1, maximum cycles of each night phase (OFF or YY).

Ports:
- clock  in  1  system clock; all sampling on posedge.
- reset  in  1  asynchronous, active-high reset.
- redA, yellowA, greenA  in  1 each  lamp lines, road A.
- redB, yellowB, greenB  in  1 each  lamp lines, road B.
- phase  out  3  decoded phase: 0 GR, 1 YR, 2 RG, 3 RY, 4 OFF, 5 YY, 7 INVALID.
- night  out  1  high while the decoded phase is OFF or YY.
- locked  out  1  high once the monitor is tracking a valid sequence.
- err_pattern  out  1  one-cycle pulse: sampled pattern is not one of the six legal codes.
- err_trans  out  1  one-cycle pulse: illegal phase transition.
- err_dwell  out  1  one-cycle pulse: dwell-time violation.
- err_sticky  out  1  set by any error pulse; cleared only by reset.
- err_count  out  8  count of error events, saturating at 255.

Behaviour:
- Lamp vector order is {redA, yellowA, greenA, redB, yellowB, greenB}. Legal codes: GR 001100, YR 010100, RG 100001, RY 100010, OFF 000000, YY 010010. Any other code is INVALID.
- Reset (asynchronous, active-high) forces:
  - phase = 7, night = 0, locked = 0, all err outputs = 0, err_count = 0.
  - internal FSM = SYNC, dwell = 0.
- Latency: the lamps are sampled at each posedge, and every output is registered from that sample. A lamp change is reflected one clock edge later.
- FSM, state SYNC:
  - On a valid code: record the phase, set dwell = 1, go to TRACK, set locked = 1. No transition or dwell check on this first sample.
  - On an invalid code: pulse err_pattern and stay in SYNC.
- FSM, state TRACK, same phase as the previous sample: dwell increments, saturating at 15.
  - If dwell exceeds its phase limit (GREEN_MAX, YELLOW_CYCLES or BLINK_CYCLES), pulse err_dwell once, on the cycle it is first exceeded.
- FSM, state TRACK, phase change: check the transition against the legal list.
  - Legal transitions: GR→YR, YR→RG, RG→RY, RY→GR; any day phase (GR, YR, RG, RY)→OFF; OFF↔YY; OFF→GR; YY→GR.
  - Illegal transition: pulse err_trans and stay in TRACK with the new phase.
  - Leaving GR→YR or RG→RY with dwell < GREEN_MIN: pulse err_dwell.
  - Leaving a day phase for OFF is a mode switch and is never a dwell error.
  - dwell restarts at 1 in the new phase.
- FSM, state TRACK, invalid code: pulse err_pattern, set phase = 7, drop locked, go to SYNC. No err_trans is raised.
- Simultaneous errors on one sample (for example err_trans and err_dwell): both pulses assert, and err_count increments by 1 per erroring sample, not per flag.
- err_count holds at 255 once saturated. err_sticky is the OR of all past pulses.

Optional Feature:
- Macro: SEMAFORO_MON_STATS_EN.
- When defined, an extra output `cycles_done` (16 bits, reset 0, wraps at 65535) is present. It increments on each legal RY→GR transition seen in TRACK, i.e. one completed day cycle.
- When not defined, the port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Reset, then GR×4, YR, RG×3, RY, GR×3 → phase steps 0,1,2,3,0; locked = 1 from the first sample; no error pulses; err_count = 0; with STATS_EN, cycles_done = 1.
- GR×2 then YR → err_dwell pulses one cycle after YR is sampled; err_count = 1; err_sticky = 1.
- GR×3 then RG → err_trans pulses; phase = 2; err_count = 1.
- Inject 001001 during RG → err_pattern pulses, phase = 7, locked = 0. The next RG is sampled with no error, and locked returns to 1.
- GR×2, OFF, YY, OFF, YY, YY → no error through the alternating section. The second consecutive YY pulses err_dwell; night = 1 throughout the night section. Then GR → legal, night = 0.
- Hold an invalid pattern for 300 cycles → err_count saturates at 255. Assert reset mid-stream → all outputs return to their reset values immediately, without waiting for a clock edge.
